// File: rtl/instruction_fetch_stage.sv
// -----------------------------------------------------------------------------
// instruction_fetch_stage
//
// Fetch stage of a 5-stage RV32I pipeline. Owns the PC register, drives the
// instruction-memory address and loads the IF/ID pipeline register. It obeys
// the hazard unit's enables, takes EX-stage branch redirects, and parks the
// front end in HALT after capturing an EBREAK until a redirect or reset.
//
// Parameters
//   RESET_PC   PC value loaded on reset (bits [1:0] must be 0)
//   NOP_INSTR  bubble encoding written into IF/ID (addi x0,x0,0)
//
// Ports
//   clk             in   single clock, rising edge
//   reset           in   synchronous, active-low reset
//   enable_PCWrite  in   1 = PC may advance, 0 = hold PC
//   enable_Write    in   1 = IF/ID may load, 0 = hold IF/ID
//   branch_taken    in   EX-stage redirect request
//   branch_target   in   redirect address, bits [1:0] forced to 0
//   imem_addr       out  current PC
//   imem_rdata      in   instruction at imem_addr (combinational ROM)
//   ifid_pc         out  PC of the instruction held in IF/ID
//   ifid_instr      out  instruction held in IF/ID
//   ifid_valid      out  1 = real instruction, 0 = bubble
//   halted          out  1 while in HALT (registered)
//   stall_count     out  RUN-state PC stall counter (FETCH_STALL_COUNT_EN only)
//   dbg_state_o     out  FSM state encoding for debug/checkers
//
// Optional feature macro: FETCH_STALL_COUNT_EN adds the stall_count port and
// its saturating counter. Without it, all other behaviour is identical.
//
// Handshake note: there is no valid/ready handshake on this block. The hazard
// unit's enables are level-sampled each rising edge; a branch redirect is a
// single-cycle request that always wins over both enables.
// -----------------------------------------------------------------------------
module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable_PCWrite,
  input  logic        enable_Write,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_instr,
  output logic        ifid_valid,
  output logic        halted,
`ifdef FETCH_STALL_COUNT_EN
  output logic [31:0] stall_count,
`endif
  output logic [1:0]  dbg_state_o
);

  localparam logic [31:0] EBREAK_INSTR = 32'h0010_0073;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic        halted_q, halted_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Redirect target with the byte offset dropped so the PC stays word aligned.
  logic [31:0] redirect_pc;
  logic [31:0] pc_plus4;

  assign redirect_pc = {branch_target[31:2], 2'b00};
  assign pc_plus4    = pc_q + 32'd4;   // wraps naturally at 2^32

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
    stall_cnt_d  = stall_cnt_q;

    unique case (state_q)
      // One cycle with the PC held so IF/ID starts from a clean bubble.
      ST_BOOT: begin
        ifid_pc_d    = 32'd0;
        ifid_instr_d = NOP_INSTR;
        ifid_valid_d = 1'b0;
        state_d      = ST_RUN;
      end

      ST_RUN: begin
        if (branch_taken) begin
          // Redirect overrides both enables and squashes whatever sits in ID.
          pc_d         = redirect_pc;
          ifid_pc_d    = 32'd0;
          ifid_instr_d = NOP_INSTR;
          ifid_valid_d = 1'b0;
        end else begin
          if (enable_PCWrite) begin
            pc_d = pc_plus4;
          end else if (stall_cnt_q != 32'hFFFF_FFFF) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
          end

          if (enable_Write) begin
            ifid_pc_d    = pc_q;
            ifid_instr_d = imem_rdata;
            ifid_valid_d = 1'b1;
            // The EBREAK itself is kept in IF/ID as a valid instruction.
            if (imem_rdata == EBREAK_INSTR) begin
              state_d = ST_HALT;
            end
          end
        end
      end

      ST_HALT: begin
        if (branch_taken) begin
          pc_d         = redirect_pc;
          ifid_pc_d    = 32'd0;
          ifid_instr_d = NOP_INSTR;
          ifid_valid_d = 1'b0;
          state_d      = ST_RUN;
        end else if (enable_Write) begin
          // Drain the decode side with bubbles while the PC stays frozen.
          ifid_pc_d    = 32'd0;
          ifid_instr_d = NOP_INSTR;
          ifid_valid_d = 1'b0;
        end
      end

      default: begin
        state_d = ST_BOOT;
      end
    endcase

    // halted is registered from the next state, so it has no input-to-output
    // combinational path and always equals (state_q == ST_HALT).
    halted_d = (state_d == ST_HALT);
  end

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_BOOT;
      pc_q         <= RESET_PC;
      ifid_pc_q    <= 32'd0;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
      halted_q     <= 1'b0;
      stall_cnt_q  <= 32'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
      halted_q     <= halted_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign imem_addr   = pc_q;
  assign ifid_pc     = ifid_pc_q;
  assign ifid_instr  = ifid_instr_q;
  assign ifid_valid  = ifid_valid_q;
  assign halted      = halted_q;
  assign dbg_state_o = state_q;

`ifdef FETCH_STALL_COUNT_EN
  assign stall_count = stall_cnt_q;
`else
  // Counter is not observable in this build; keep it from being flagged unused.
  logic unused_stall_cnt;
  assign unused_stall_cnt = ^stall_cnt_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch_stage
//
// Drives instruction_fetch_stage from a combinational ROM, first through a
// directed sequence with literal expectations, then with random enables,
// redirects and resets. A behavioural model of the fetch front end runs on
// every rising edge and a compare process checks every output on each
// falling edge.
// -----------------------------------------------------------------------------
module tb_instruction_fetch_stage;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] EBREAK    = 32'h0010_0073;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        reset;
  logic        enable_PCWrite;
  logic        enable_Write;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_instr;
  logic        ifid_valid;
  logic        halted;
  logic [1:0]  dbg_state;
`ifdef FETCH_STALL_COUNT_EN
  logic [31:0] stall_count;
`endif

  always #5 clk = ~clk;

  // ROM covers 256 words; the address simply aliases above 0x3FF.
  logic [31:0] rom [0:255];
  assign imem_rdata = rom[imem_addr[9:2]];

  instruction_fetch_stage #(
    .RESET_PC (RESET_PC),
    .NOP_INSTR(NOP_INSTR)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable_PCWrite(enable_PCWrite),
    .enable_Write  (enable_Write),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .ifid_pc       (ifid_pc),
    .ifid_instr    (ifid_instr),
    .ifid_valid    (ifid_valid),
    .halted        (halted),
`ifdef FETCH_STALL_COUNT_EN
    .stall_count   (stall_count),
`endif
    .dbg_state_o   (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard bookkeeping
  // ---------------------------------------------------------------------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: the front end is either starting up, fetching, or
  // parked; the IF/ID contents are a (pc, instr, valid) triple.
  // ---------------------------------------------------------------------------
  bit          m_started;   // the post-reset warm-up edge has happened
  bit          m_parked;    // front end halted by an EBREAK
  logic [31:0] m_pc;
  logic [31:0] m_ipc;
  logic [31:0] m_instr;
  bit          m_valid;
  longint      m_stalls;
  bit          model_live = 1'b0;

  always @(posedge clk) begin
    logic [31:0] fetched;
    fetched = rom[m_pc[9:2]];
    if (!reset) begin
      m_started = 1'b0;
      m_parked  = 1'b0;
      m_pc      = RESET_PC;
      m_ipc     = 32'd0;
      m_instr   = NOP_INSTR;
      m_valid   = 1'b0;
      m_stalls  = 0;
      model_live = 1'b1;
    end else if (!m_started) begin
      m_started = 1'b1;
      m_ipc = 32'd0; m_instr = NOP_INSTR; m_valid = 1'b0;
    end else if (branch_taken) begin
      m_pc    = branch_target & 32'hFFFF_FFFC;
      m_ipc   = 32'd0; m_instr = NOP_INSTR; m_valid = 1'b0;
      m_parked = 1'b0;
    end else if (m_parked) begin
      if (enable_Write) begin
        m_ipc = 32'd0; m_instr = NOP_INSTR; m_valid = 1'b0;
      end
    end else begin
      if (enable_Write) begin
        m_ipc = m_pc; m_instr = fetched; m_valid = 1'b1;
        if (fetched == EBREAK) m_parked = 1'b1;
      end
      if (enable_PCWrite) m_pc = 32'((64'(m_pc) + 64'd4) % 64'h1_0000_0000);
      else if (m_stalls < 64'hFFFF_FFFF) m_stalls++;
    end
  end

  // One compare process: every output on every falling edge once the model
  // has seen a reset.
  always @(negedge clk) begin
    if (model_live) begin
      chk("imem_addr",  imem_addr,  m_pc);
      chk("ifid_pc",    ifid_pc,    m_ipc);
      chk("ifid_instr", ifid_instr, m_instr);
      chk("ifid_valid", {31'd0, ifid_valid}, {31'd0, m_valid});
      chk("halted",     {31'd0, halted},     {31'd0, m_parked});
`ifdef FETCH_STALL_COUNT_EN
      chk("stall_count", stall_count, m_stalls[31:0]);
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Driver helpers (inputs change just after the falling edge)
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic pcw, input logic wr, input logic br, input logic [31:0] tgt);
    enable_PCWrite = pcw;
    enable_Write   = wr;
    branch_taken   = br;
    branch_target  = tgt;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    // Filler opcode 0x33 (R-type) can never match EBREAK.
    for (int i = 0; i < 256; i++) rom[i] = {$urandom() & 32'hFFFF_FF80} | 32'h33;
    rom[0] = 32'h00A0_0093;
    rom[8] = EBREAK;              // address 0x20

    reset = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 32'd0);
    tick();
    tick();
    chk("rst_addr",  imem_addr, RESET_PC);
    chk("rst_halt",  {31'd0, halted}, 32'd0);
    chk("rst_valid", {31'd0, ifid_valid}, 32'd0);
    chk("rst_instr", ifid_instr, NOP_INSTR);

    // Release: addresses 0,0,4,8; first valid entry on the 2nd edge.
    reset = 1'b1;
    chk("boot_addr0", imem_addr, 32'h0);
    tick();
    chk("boot_addr1", imem_addr, 32'h0);
    chk("boot_valid", {31'd0, ifid_valid}, 32'd0);
    tick();
    chk("first_addr",  imem_addr, 32'h4);
    chk("first_valid", {31'd0, ifid_valid}, 32'd1);
    chk("first_pc",    ifid_pc, 32'h0);
    chk("first_instr", ifid_instr, 32'h00A0_0093);
    tick();
    chk("seq_addr8", imem_addr, 32'h8);
    tick();
    tick();
    chk("pre_stall_addr", imem_addr, 32'h10);

    // Load-use stall for one cycle at pc 0x10.
    drive(1'b0, 1'b0, 1'b0, 32'd0);
    tick();
    chk("stall_addr",  imem_addr, 32'h10);
    chk("stall_ipc",   ifid_pc, 32'hC);
    chk("stall_instr", ifid_instr, rom[3]);
`ifdef FETCH_STALL_COUNT_EN
    chk("stall_cnt1", stall_count, 32'd1);
`endif
    drive(1'b1, 1'b1, 1'b0, 32'd0);
    tick();
    chk("resume_addr", imem_addr, 32'h14);
    chk("resume_ipc",  ifid_pc, 32'h10);

    // Redirect with a stall in the same cycle: redirect wins.
    drive(1'b0, 1'b0, 1'b1, 32'h43);
    tick();
    chk("br_addr",  imem_addr, 32'h40);
    chk("br_valid", {31'd0, ifid_valid}, 32'd0);
    chk("br_instr", ifid_instr, NOP_INSTR);

    // EBREAK at 0x20.
    drive(1'b1, 1'b1, 1'b1, 32'h20);
    tick();
    drive(1'b1, 1'b1, 1'b0, 32'd0);
    tick();
    chk("ebk_instr", ifid_instr, EBREAK);
    chk("ebk_valid", {31'd0, ifid_valid}, 32'd1);
    chk("ebk_halt",  {31'd0, halted}, 32'd1);
    chk("ebk_addr",  imem_addr, 32'h24);
    tick();
    tick();
    chk("halt_addr",  imem_addr, 32'h24);
    chk("halt_valid", {31'd0, ifid_valid}, 32'd0);
    drive(1'b1, 1'b1, 1'b1, 32'h80);
    tick();
    chk("unhalt_halt", {31'd0, halted}, 32'd0);
    chk("unhalt_addr", imem_addr, 32'h80);

    // PC wrap.
    drive(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF);
    tick();
    chk("wrap_top", imem_addr, 32'hFFFF_FFFC);
    drive(1'b1, 1'b1, 1'b0, 32'd0);
    tick();
    chk("wrap_zero", imem_addr, 32'h0);

    // Reset while halted at 0x24.
    drive(1'b1, 1'b1, 1'b1, 32'h20);
    tick();
    drive(1'b1, 1'b1, 1'b0, 32'd0);
    tick();
    tick();
    chk("rh_pre_addr", imem_addr, 32'h24);
    chk("rh_pre_halt", {31'd0, halted}, 32'd1);
    reset = 1'b0;
    tick();
    chk("rh_addr",  imem_addr, RESET_PC);
    chk("rh_halt",  {31'd0, halted}, 32'd0);
    chk("rh_valid", {31'd0, ifid_valid}, 32'd0);
    reset = 1'b1;

    // Random phase: sprinkle EBREAKs so HALT is visited repeatedly.
    for (int i = 1; i < 256; i++)
      if ($urandom_range(0, 99) < 4) rom[i] = EBREAK;
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] tgt;
      reset = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 19) == 0) tgt = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      else                            tgt = 32'($urandom_range(0, 1023));
      drive($urandom_range(0, 99) < 75, $urandom_range(0, 99) < 80,
            $urandom_range(0, 99) < 10, tgt);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_stage.md
# instruction_fetch_stage

- Fetch stage of the 5-stage RV32I pipeline.
- Owns the PC register, drives the instruction-memory address, and loads the IF/ID pipeline register.
- Consumes the hazard-detection controls (`enable_PCWrite`, `enable_Write`) and the EX-stage branch redirect.
- Detects EBREAK and parks the front end in a halted state until a redirect or reset.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- `NOP_INSTR`, 32'h0000_0013, bubble encoding (`addi x0,x0,0`) written into IF/ID on flush or stall-bubble.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `enable_PCWrite`  in  1  from hazard detection; 1 = PC may advance, 0 = hold PC.
- `enable_Write`  in  1  from hazard detection; 1 = IF/ID may load, 0 = hold IF/ID.
- `branch_taken`  in  1  EX-stage redirect request.
- `branch_target`  in  32  redirect address; bits [1:0] are ignored and forced to 0.
- `imem_addr`  out  32  equals the current PC; combinational from the PC register.
- `imem_rdata`  in  32  instruction at `imem_addr`, valid in the same cycle (combinational ROM).
- `ifid_pc`  out  32  PC of the instruction held in IF/ID.
- `ifid_instr`  out  32  instruction held in IF/ID.
- `ifid_valid`  out  1  1 = IF/ID holds a real instruction; 0 = bubble.
- `halted`  out  1  1 while the FSM is in HALT.
- `stall_count`  out  32  present only when the macro in Configuration is defined.

## Operation
- FSM states: BOOT, RUN, HALT.

**Reset** (`reset`==0 at an edge), regardless of state:
- pc <= `RESET_PC`; ifid_instr <= `NOP_INSTR`; ifid_pc <= 0; ifid_valid <= 0; state <= BOOT; stall_count <= 0.
- `halted` = 0.

**BOOT**
- Lasts exactly one cycle.
- PC held; IF/ID loads a bubble.
- Next state is RUN unconditionally; `branch_taken` is ignored.

**RUN**, priority order (first match wins):
1. `branch_taken`:
   - pc <= {branch_target[31:2],2'b00}.
   - IF/ID <= bubble (instr `NOP_INSTR`, valid 0, ifid_pc 0).
   - Applies even if either enable is 0.
2. Otherwise, `enable_PCWrite` and `enable_Write` act independently:
   - `enable_PCWrite`: 1 -> pc <= pc+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0); 0 -> PC held.
   - `enable_Write`: 1 -> ifid_instr <= imem_rdata, ifid_pc <= pc, ifid_valid <= 1; 0 -> IF/ID held unchanged.
3. EBREAK capture: if IF/ID loads `imem_rdata`==32'h0010_0073 this edge, next state is HALT. The EBREAK stays in IF/ID with valid 1.

**HALT**
- `halted`=1.
- PC held.
- IF/ID loads a bubble on each edge with `enable_Write`=1; otherwise held.
- `branch_taken` -> same redirect as RUN, state <= RUN.

## Timing
- Redirect latency 1 cycle: target appears on `imem_addr` the cycle after `branch_taken` is sampled.
- First fetch: `imem_addr`=`RESET_PC` from the first cycle after reset release. The first valid IF/ID entry appears 2 edges after release (BOOT edge, then RUN capture).
- Simultaneous `branch_taken` and load-use stall: the redirect wins; the stalled ID instruction is squashed.
- Reset asserted mid-redirect or mid-stall: reset wins; all pending effects are discarded.
- `halted` is a registered state decode with no combinational path from the inputs.

## Configuration
- `FETCH_STALL_COUNT_EN` defined:
  - `stall_count` port exists.
  - Increments by 1 on every RUN edge with `enable_PCWrite`==0 and `branch_taken`==0.
  - Saturates at 32'hFFFF_FFFF; cleared only by reset.
- Undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- Reset release, imem returns 0x00A00093 at 0 -> `imem_addr` sequence 0,0,4,8.
  - ifid_valid first 1 on the 2nd edge after release, with ifid_pc=0, ifid_instr=0x00A00093.
- Load-use stall: enable_PCWrite=enable_Write=0 for 1 cycle while pc=0x10 -> pc stays 0x10 and IF/ID holds its prior value.
  - Resumes 0x14 next edge; stall_count=1 when `FETCH_STALL_COUNT_EN` is defined.
- branch_taken=1, branch_target=0x43 with stall active the same cycle -> pc=0x40 next edge, ifid_valid=0, ifid_instr=0x00000013.
- imem returns 0x00100073 at pc=0x20 -> ifid_instr=0x00100073, halted=1 next cycle.
  - pc frozen at 0x24 thereafter.
  - branch_taken with target 0x80 -> halted=0, pc=0x80.
- pc forced to 0xFFFF_FFFC via redirect, then an advance -> pc=0x0000_0000.
- Reset driven low while halted with pc=0x24 -> one edge later pc=`RESET_PC`, halted=0, ifid_valid=0.
